vce_frame_capture: RTL

//  Sink for the HuC6260 VCE video output. Samples VIDEO_R/G/B at the dot rate and decodes HSYNC_n/VSYNC_n.

---
 rtl/vce_frame_capture.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vce_frame_capture.sv
// HuC6260 VCE video sink: decodes sync, turns the active picture into (x, y, GRB) pixel writes
// through a small valid/ready FIFO. Define CAPTURE_STATS_EN to add line_len/frame_lines outputs.
module vce_frame_capture #(
    parameter int unsigned H_START    = 38,
    parameter int unsigned H_ACTIVE   = 256,
    parameter int unsigned V_START    = 14,
    parameter int unsigned V_ACTIVE   = 224,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       HSYNC_n,
    input  logic       VSYNC_n,
    input  logic [2:0] VIDEO_R,
    input  logic [2:0] VIDEO_G,
    input  logic [2:0] VIDEO_B,
    output logic       fb_valid,
    input  logic       fb_ready,
    output logic [8:0] fb_x,
    output logic [7:0] fb_y,
    output logic [8:0] fb_data,
    output logic       frame_done,
    output logic       overflow
`ifdef CAPTURE_STATS_EN
    ,
    output logic [9:0] line_len,
    output logic [8:0] frame_lines
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0]  X_LAST     = 9'(H_ACTIVE - 1);
    localparam logic [7:0]  Y_LAST     = 8'(V_ACTIVE - 1);
    localparam logic [8:0]  HCNT_LAST  = 9'(H_START - 1);
    localparam logic [7:0]  LINE_START = 8'(V_START);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

    typedef enum logic [2:0] {StWaitVs, StVSkip, StHSkip, StActive, StHWait} state_e;

    // ------------------------------------------------------------------
    // Sync input registers and dot-rate edge detection
    // ------------------------------------------------------------------
    logic hs_s, vs_s, hs_prev, vs_prev;
    logic hs_fall, vs_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_s    <= 1'b1;
            vs_s    <= 1'b1;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_s <= HSYNC_n;
            vs_s <= VSYNC_n;
            if (dot_en) begin
                hs_prev <= hs_s;
                vs_prev <= vs_s;
            end
        end
    end

    assign hs_fall = dot_en & hs_prev & ~hs_s;
    assign vs_fall = dot_en & vs_prev & ~vs_s;

    // ------------------------------------------------------------------
    // Raster FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [7:0]  line_q, line_d;
    logic [8:0]  hcnt_q, hcnt_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        push_d, push_q;
    logic [25:0] push_entry_q;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        hcnt_d  = hcnt_q;
        x_d     = x_q;
        y_d     = y_q;
        push_d  = 1'b0;
        if (dot_en) begin
            if (vs_fall) begin
                // A VSYNC edge restarts vertical timing from any state.
                state_d = StVSkip;
                line_d  = '0;
            end else begin
                unique case (state_q)
                    StWaitVs: state_d = StWaitVs;
                    StVSkip: begin
                        if (hs_fall) begin
                            line_d = line_q + 8'd1;
                            if (line_d == LINE_START) begin
                                state_d = StHSkip;
                                y_d     = '0;
                                hcnt_d  = '0;
                            end
                        end
                    end
                    StHSkip: begin
                        hcnt_d = hcnt_q + 9'd1;
                        if (hcnt_d == HCNT_LAST) begin
                            state_d = StActive;
                            x_d     = '0;
                        end
                    end
                    StActive: begin
                        if (hs_fall) begin
                            // Short line: close it out, remaining columns are never written.
                            hcnt_d = '0;
                            if (y_q == Y_LAST) begin
                                state_d = StWaitVs;
                            end else begin
                                y_d     = y_q + 8'd1;
                                state_d = StHSkip;
                            end
                        end else begin
                            push_d = 1'b1;
                            if (x_q == X_LAST) begin
                                state_d = StHWait;
                            end else begin
                                x_d = x_q + 9'd1;
                            end
                        end
                    end
                    StHWait: begin
                        if (hs_fall) begin
                            hcnt_d = '0;
                            if (y_q == Y_LAST) begin
                                state_d = StWaitVs;
                            end else begin
                                y_d     = y_q + 8'd1;
                                state_d = StHSkip;
                            end
                        end
                    end
                    default: state_d = StWaitVs;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StWaitVs;
            line_q       <= '0;
            hcnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            hcnt_q  <= hcnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            push_q  <= push_d;
            if (push_d) begin
                push_entry_q <= {VIDEO_G, VIDEO_R, VIDEO_B, x_q, y_q};
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel FIFO: entry = {data[8:0], x[8:0], y[7:0]}
    // ------------------------------------------------------------------
    logic [25:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        empty, full, pop, wr;
    logic [25:0] rd_entry;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fb_valid = ~empty;
    assign pop      = fb_valid & fb_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign wr       = push_q & (~full | pop);
    assign rd_entry = mem_q[rptr_q[AW-1:0]];

    assign fb_data = fb_valid ? rd_entry[25:17] : '0;
    assign fb_x    = fb_valid ? rd_entry[16:8]  : '0;
    assign fb_y    = fb_valid ? rd_entry[7:0]   : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wr) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (push_q && !wr) begin
                overflow <= 1'b1;
            end
            frame_done <= pop && (rd_entry[16:0] == {X_LAST, Y_LAST});
        end
    end

    always_ff @(posedge clock) begin
        if (wr) begin
            mem_q[wptr_q[AW-1:0]] <= push_entry_q;
        end
    end

`ifdef CAPTURE_STATS_EN
    // ------------------------------------------------------------------
    // Timing measurement between consecutive sync edges
    // ------------------------------------------------------------------
    logic [9:0] dot_cnt_q;
    logic [8:0] hs_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            dot_cnt_q   <= '0;
            hs_cnt_q    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else if (dot_en) begin
            if (hs_fall) begin
                line_len  <= dot_cnt_q;
                dot_cnt_q <= 10'd1;
            end else begin
                dot_cnt_q <= dot_cnt_q + 10'd1;
            end
            // An HSYNC edge coinciding with VSYNC belongs to the new frame.
            if (vs_fall) begin
                frame_lines <= hs_cnt_q;
                hs_cnt_q    <= {8'd0, hs_fall};
            end else if (hs_fall) begin
                hs_cnt_q <= hs_cnt_q + 9'd1;
            end
        end
    end
`endif

endmodule
